// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and instruction-fetch front end.
// Issues one fetch at a time over a req/ready/rvalid memory interface and
// presents the instruction plus incremented PC to IF/ID. Redirects from
// next_pc flush IF/ID and the skid entry and discard any in-flight fetch.
// Optional macro PC_FETCH_PERF_EN adds saturating redirect/kill counters.
`timescale 1ns/1ps

module pc_fetch_unit #(
    parameter int unsigned          PC_W     = 30,
    parameter logic [PC_W-1:0]      RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_PCSrc,
    input  logic [PC_W-1:0]     i_jump_adress,
    output logic                o_imem_req,
    output logic [PC_W-1:0]     o_imem_addr,
    input  logic                i_imem_ready,
    input  logic                i_imem_rvalid,
    input  logic [31:0]         i_imem_rdata,
    output logic                o_valid,
    output logic [31:0]         o_instr,
    output logic [PC_W-1:0]     o_inc_pc
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [15:0]         o_redirect_cnt,
    output logic [15:0]         o_kill_cnt
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]         state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    req_addr;
    logic               skid_valid;
    logic [31:0]        skid_instr;
    logic [PC_W-1:0]    skid_inc_pc;

    logic               xfer;
    logic               deliver;
    logic [PC_W-1:0]    resp_inc_pc;

    assign o_imem_req  = (state == IDLE) & ~skid_valid & ~i_PCSrc & ~i_rst;
    assign o_imem_addr = pc;
    assign xfer        = o_imem_req & i_imem_ready;
    // A response racing a redirect is wrong-path data and never delivered.
    assign deliver     = (state == WAIT) & i_imem_rvalid & ~i_PCSrc;
    assign resp_inc_pc = req_addr + PC_W'(1);

    // PC, outstanding request address and fetch FSM.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= '0;
        end else begin
            if (i_PCSrc) begin
                pc <= i_jump_adress;
            end else if (xfer) begin
                req_addr <= pc;
                pc       <= pc + PC_W'(1);
            end
            case (state)
                IDLE:    if (xfer) state <= WAIT;
                WAIT: begin
                    if (i_imem_rvalid)  state <= IDLE;
                    else if (i_PCSrc)   state <= DISCARD;
                end
                // The outstanding response still has to drain even if
                // further redirects arrive while waiting for it.
                DISCARD: if (i_imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // IF/ID output registers and the one-entry skid buffer behind them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_instr     <= '0;
            o_inc_pc    <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_inc_pc <= '0;
        end else if (i_PCSrc) begin
            o_valid    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (deliver) begin
            // Skid is always empty here: a full skid blocks new requests.
            if (~o_valid | ~i_stall) begin
                o_valid  <= 1'b1;
                o_instr  <= i_imem_rdata;
                o_inc_pc <= resp_inc_pc;
            end else begin
                skid_valid  <= 1'b1;
                skid_instr  <= i_imem_rdata;
                skid_inc_pc <= resp_inc_pc;
            end
        end else if (~i_stall) begin
            if (skid_valid) begin
                o_valid    <= 1'b1;
                o_instr    <= skid_instr;
                o_inc_pc   <= skid_inc_pc;
                skid_valid <= 1'b0;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef PC_FETCH_PERF_EN
    logic        dropped;
    logic [1:0]  kill_inc;
    logic [16:0] kill_sum;
    logic [16:0] redir_sum;

    // Per-cycle kill count: dropped response plus flushed IF/ID and skid entries.
    always_comb begin
        dropped   = i_imem_rvalid & ((state == DISCARD) | ((state == WAIT) & i_PCSrc));
        kill_inc  = {1'b0, dropped} + {1'b0, i_PCSrc & o_valid} + {1'b0, i_PCSrc & skid_valid};
        kill_sum  = {1'b0, o_kill_cnt} + {15'd0, kill_inc};
        redir_sum = {1'b0, o_redirect_cnt} + {16'd0, i_PCSrc};
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_redirect_cnt <= '0;
            o_kill_cnt     <= '0;
        end else begin
            o_redirect_cnt <= redir_sum[16] ? 16'hFFFF : redir_sum[15:0];
            o_kill_cnt     <= kill_sum[16]  ? 16'hFFFF : kill_sum[15:0];
        end
    end
`endif

endmodule
